fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: AW, 16, instruction-memory address width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_addr  output  AW  byte address of the current read request.
REQ-005 mem_rd  output  1  read request; held high until acknowledged.
REQ-006 mem_data  input  8  read data; valid when mem_ack=1.
REQ-007 mem_ack  input  1  read acknowledge; may be asserted in the same cycle as mem_rd.
REQ-008 pc_in  input  AW  redirect target address.
REQ-009 pc_load  input  1  redirect strobe (jump/branch).
REQ-010 len  input  2  operand byte count (0-3) from the decode block for the current insn.
REQ-011 done  input  1  decode/execute signals the current instruction is complete.
REQ-012 insn  output  8  opcode byte to the decode block.
REQ-013 d1, d2, d3  output  8 each  operand bytes 1-3 to the decode block.
REQ-014 is  output  3  instruction step counter to the decode block.
REQ-015 valid  output  1  insn/d1-d3 are complete and stable.
REQ-016 insn_pc  output  AW  address of the opcode of the current instruction.

Function
REQ-017 States SHALL be FETCH_OP, DECODE, FETCH_OPR, EXEC.
REQ-018 FETCH_OP: mem_rd=1, mem_addr=fptr; on mem_ack: insn<=mem_data, insn_pc<=fptr, d1/d2/d3<=0, fptr<=fptr+1, cnt<=0, go to DECODE.
REQ-019 DECODE: exactly one cycle, mem_rd=0; latch need<=len; need=0 -> EXEC, else -> FETCH_OPR.
REQ-020 FETCH_OPR: mem_rd=1, mem_addr=fptr; on mem_ack: d(cnt+1)<=mem_data, fptr<=fptr+1, cnt<=cnt+1; when cnt+1==need go to EXEC.
REQ-021 EXEC: valid=1, mem_rd=0; is starts at 0 on entry and increments by 1 each cycle, saturating at 7.
REQ-022 EXEC with done=1: next state FETCH_OP, valid<=0, is<=0 in the same edge.
REQ-023 mem_ack while mem_rd=0 SHALL be ignored.
REQ-024 insn, d1-d3 and insn_pc SHALL NOT change while valid=1.
REQ-025 fptr SHALL wrap from 2^AW-1 to 0 with no error indication.
REQ-026 pc_load=1 in any state SHALL take priority over mem_ack and done: fptr<=pc_in, state<=FETCH_OP, valid<=0, is<=0, cnt<=0; the data of any ack in that cycle is discarded.
REQ-027 mem_rd SHALL be 0 in the cycle after a pc_load, and the new request SHALL start the following cycle.
REQ-028 len SHALL be sampled only in DECODE; len changes at other times have no effect.
REQ-029 Zero-wait-state memory (ack every requested cycle) SHALL give a latency of 2+need cycles from entry into FETCH_OP to valid=1.

Reset
REQ-030 With rst=1 at an edge: state=FETCH_OP, fptr=0, insn_pc=0, insn=d1=d2=d3=0, is=0, valid=0, cnt=0, need=0.
REQ-031 rst SHALL override pc_load, mem_ack and done; mem_rd SHALL be 0 during reset and 1 in the first cycle after release.
REQ-032 Reset mid-operation SHALL abandon the pending read and partial operands with no further outputs.

Verification
REQ-033 Zero-wait memory, byte 0x0D at 0, len=3, bytes 100/50/64 at 1-3 -> valid=1 on the 5th edge after reset release; insn=13, d1=100, d2=50, d3=64, insn_pc=0, is=0.
REQ-034 Hold done=0 for 10 cycles in EXEC -> is counts 0..7, then stays 7; outputs stable; mem_rd=0.
REQ-035 Opcode 0x18 at address 4, len=0, after done -> DECODE then EXEC; insn=24, d1-d3=0, insn_pc=4.
REQ-036 Assert pc_load with pc_in=0x0100 in the same cycle as mem_ack during FETCH_OPR -> byte discarded, mem_rd=0 for one cycle, then mem_addr=0x0100.
REQ-037 fptr=0xFFFF, len=2 -> operands read from 0x0000 and 0x0001; insn_pc=0xFFFF.
REQ-038 Memory acks after 3 wait cycles, with a spurious mem_ack while mem_rd=0 -> the spurious ack is ignored, each byte is captured exactly once, and mem_addr is held for the whole wait.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetcher that reads an opcode and 0-3 operand bytes, then holds them for decode/execute
//   clk, rst              : clock, synchronous active-high reset
//   mem_addr/mem_rd       : read request (address held until acknowledged)
//   mem_data/mem_ack      : read response, ignored unless a request is outstanding
//   pc_in/pc_load         : redirect target and strobe (highest priority after rst)
//   len/done              : operand count sampled in DECODE, instruction-complete strobe
//   insn/d1-d3/insn_pc    : current instruction bytes and opcode address
//   is/valid              : execute step counter (saturating) and instruction-ready flag
module fetch_unit #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    input  logic          mem_ack,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_load,
    input  logic [1:0]    len,
    input  logic          done,
    output logic [7:0]    insn,
    output logic [7:0]    d1,
    output logic [7:0]    d2,
    output logic [7:0]    d3,
    output logic [2:0]    is,
    output logic          valid,
    output logic [AW-1:0] insn_pc
);
    typedef enum logic [1:0] {FETCH_OP, DECODE, FETCH_OPR, EXEC} state_t;
    state_t          state_q, state_d;
    logic [AW-1:0]   fptr_q, fptr_d, insn_pc_q, insn_pc_d;
    logic [7:0]      insn_q, insn_d;
    logic [2:0][7:0] d_q, d_d;
    logic [2:0]      is_q, is_d;
    logic [1:0]      cnt_q, cnt_d, need_q, need_d;
    logic            skip_q, skip_d;
    logic            ack;
    // skip_q holds off the request for the one cycle following a redirect
    assign mem_rd   = !rst && !skip_q && (state_q == FETCH_OP || state_q == FETCH_OPR);
    assign ack      = mem_rd && mem_ack;
    assign mem_addr = fptr_q;
    assign insn     = insn_q;
    assign d1       = d_q[0];
    assign d2       = d_q[1];
    assign d3       = d_q[2];
    assign is       = is_q;
    assign valid    = state_q == EXEC;
    assign insn_pc  = insn_pc_q;
    always_comb begin
        state_d   = state_q;
        fptr_d    = fptr_q;
        insn_pc_d = insn_pc_q;
        insn_d    = insn_q;
        d_d       = d_q;
        is_d      = is_q;
        cnt_d     = cnt_q;
        need_d    = need_q;
        skip_d    = 1'b0;
        if (pc_load) begin
            fptr_d  = pc_in;
            state_d = FETCH_OP;
            is_d    = '0;
            cnt_d   = '0;
            skip_d  = 1'b1;
        end else begin
            case (state_q)
                FETCH_OP: if (ack) begin
                    insn_d    = mem_data;
                    insn_pc_d = fptr_q;
                    d_d       = '0;
                    fptr_d    = fptr_q + AW'(1);
                    cnt_d     = '0;
                    state_d   = DECODE;
                end
                DECODE: begin
                    need_d  = len;
                    state_d = len == 2'd0 ? EXEC : FETCH_OPR;
                end
                FETCH_OPR: if (ack) begin
                    d_d[cnt_q] = mem_data;
                    fptr_d     = fptr_q + AW'(1);
                    cnt_d      = cnt_q + 2'd1;
                    state_d    = cnt_d == need_q ? EXEC : FETCH_OPR;
                end
                default: begin
                    state_d = done ? FETCH_OP : EXEC;
                    is_d    = done ? 3'd0 : (is_q == 3'd7 ? 3'd7 : is_q + 3'd1);
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_OP;
            fptr_q    <= '0;
            insn_pc_q <= '0;
            insn_q    <= '0;
            d_q       <= '0;
            is_q      <= '0;
            cnt_q     <= '0;
            need_q    <= '0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fptr_q    <= fptr_d;
            insn_pc_q <= insn_pc_d;
            insn_q    <= insn_d;
            d_q       <= d_d;
            is_q      <= is_d;
            cnt_q     <= cnt_d;
            need_q    <= need_d;
            skip_q    <= skip_d;
        end
    end
endmodule
